icache_rvc_assoc: RTL

//  Parametrised read-only instruction cache for the RVC fetch path. It sits between the IF stage and the 128-bit instruction memory.
//  N-way set-associative (1 or 2 ways), LRU replacement, halfword-granular fetch.

---
 rtl/icache_pkg.sv | 14 +
 rtl/icache_way.sv | 62 ++++++
 rtl/icache_rvc_assoc.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and geometry for the RVC instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } state_t;

  localparam int OFF_W       = 3;
  localparam int HW_PER_LINE = 8;
  localparam int LINE_BITS   = 128;

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: valid/tag/data arrays, two combinational
// lookup ports (line A and line B of a fetch) and one refill write port.
module icache_way
  import icache_pkg::*;
#(
  parameter int SET_W = 2,
  parameter int TAG_W = 26
) (
  input  logic                 clk,
  input  logic                 proc_reset,
  input  logic                 clr,
  input  logic [SET_W-1:0]     set_a,
  input  logic [TAG_W-1:0]     tag_a,
  input  logic [SET_W-1:0]     set_b,
  input  logic [TAG_W-1:0]     tag_b,
  output logic                 hit_a,
  output logic                 valid_a,
  output logic [LINE_BITS-1:0] data_a,
  output logic                 hit_b,
  output logic                 valid_b,
  output logic [LINE_BITS-1:0] data_b,
  input  logic                 fill_en,
  input  logic [SET_W-1:0]     fill_set,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [LINE_BITS-1:0] fill_data
);

  localparam int SETS = 1 << SET_W;

  logic [SETS-1:0]      valid_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_set] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately left out of reset; the valid
  // bits alone decide whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_set]  <= fill_tag;
      data_q[fill_set] <= fill_data;
    end
  end

  assign valid_a = valid_q[set_a];
  assign valid_b = valid_q[set_b];
  assign hit_a   = valid_a && (tag_q[set_a] == tag_a);
  assign hit_b   = valid_b && (tag_q[set_b] == tag_b);
  assign data_a  = data_q[set_a];
  assign data_b  = data_q[set_b];

endmodule

// File: rtl/icache_rvc_assoc.sv
// Read-only, 1- or 2-way set-associative instruction cache for the RVC fetch
// path; serves halfword-aligned 32-bit fetches that may straddle two lines.
module icache_rvc_assoc
  import icache_pkg::*;
#(
  parameter int PADDR_W = 31,
  parameter int SET_W   = 2,
  parameter int WAYS    = 2
) (
  input  logic                 clk,
  input  logic                 proc_reset,
  input  logic                 proc_read,
  input  logic                 proc_write,
  input  logic                 proc_flush,
  input  logic [PADDR_W-1:0]   proc_addr,
  input  logic [31:0]          proc_wdata,
  output logic                 proc_stall,
  output logic [31:0]          proc_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [PADDR_W-4:0]   mem_addr,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic [LINE_BITS-1:0] mem_wdata
);

  localparam int LINE_W = PADDR_W - OFF_W;
  localparam int TAG_W  = LINE_W - SET_W;
  localparam int SETS   = 1 << SET_W;

  state_t               state_q, state_d;
  logic [LINE_W-1:0]    tgt_q;
  logic                 victim_q;
  logic [LINE_BITS-1:0] buf_q;
  logic                 flush_pend_q;
  logic [SETS-1:0]      lru_q;

  logic [OFF_W-1:0]     off;
  logic                 straddle;
  logic [LINE_W-1:0]    line_a, line_b, tgt_line;
  logic [SET_W-1:0]     set_a, set_b, tgt_set_q;
  logic [WAYS-1:0]      hit_a_w, hit_b_w, valid_a_w, valid_b_w, tgt_valid, fill_en_w;
  logic [LINE_BITS-1:0] data_a_w [WAYS];
  logic [LINE_BITS-1:0] data_b_w [WAYS];
  logic [LINE_BITS-1:0] data_a, data_b;
  logic                 hit_a, hit_b, hit;
  logic                 hit_way_a, hit_way_b, victim;
  logic                 clr, start;

  // Line B is the following line only when the fetch starts on the last halfword.
  assign off       = proc_addr[OFF_W-1:0];
  assign straddle  = (off == OFF_W'(HW_PER_LINE - 1));
  assign line_a    = proc_addr[PADDR_W-1:OFF_W];
  assign line_b    = line_a + {{(LINE_W-1){1'b0}}, straddle};
  assign set_a     = line_a[SET_W-1:0];
  assign set_b     = line_b[SET_W-1:0];
  assign tgt_set_q = tgt_q[SET_W-1:0];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign fill_en_w[w] = (state_q == FILL) && (victim_q == 1'(w));

    icache_way #(
      .SET_W (SET_W),
      .TAG_W (TAG_W)
    ) u_way (
      .clk        (clk),
      .proc_reset (proc_reset),
      .clr        (clr),
      .set_a      (set_a),
      .tag_a      (line_a[LINE_W-1:SET_W]),
      .set_b      (set_b),
      .tag_b      (line_b[LINE_W-1:SET_W]),
      .hit_a      (hit_a_w[w]),
      .valid_a    (valid_a_w[w]),
      .data_a     (data_a_w[w]),
      .hit_b      (hit_b_w[w]),
      .valid_b    (valid_b_w[w]),
      .data_b     (data_b_w[w]),
      .fill_en    (fill_en_w[w]),
      .fill_set   (tgt_set_q),
      .fill_tag   (tgt_q[LINE_W-1:SET_W]),
      .fill_data  (buf_q)
    );
  end

  assign hit_a     = |hit_a_w;
  assign hit_b     = |hit_b_w;
  assign hit       = hit_a && hit_b;
  assign hit_way_a = (WAYS == 2) ? hit_a_w[WAYS-1] : 1'b0;
  assign hit_way_b = (WAYS == 2) ? hit_b_w[WAYS-1] : 1'b0;

  // NOTE: every combinationally assigned signal gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    data_a = '0;
    data_b = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_a_w[w]) data_a = data_a_w[w];
      if (hit_b_w[w]) data_b = data_b_w[w];
    end
  end

  // Concatenating B above A makes a straddling fetch a plain 32-bit slice.
  logic [2*LINE_BITS-1:0] pair;
  assign pair       = {data_b, data_a};
  assign proc_rdata = pair[{off, 4'b0000} +: 32];

  // Refill the first missing line; line B is picked up on the next IDLE pass.
  assign tgt_line  = hit_a ? line_b : line_a;
  assign tgt_valid = hit_a ? valid_b_w : valid_a_w;

  if (WAYS == 2) begin : g_victim2
    assign victim = !tgt_valid[0] ? 1'b0 :
                    !tgt_valid[1] ? 1'b1 : lru_q[tgt_line[SET_W-1:0]];
  end else begin : g_victim1
    assign victim = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    clr        = 1'b0;
    start      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_pend_q || proc_flush) begin
          clr        = 1'b1;
          proc_stall = proc_read;
        end else if (proc_read && !hit) begin
          proc_stall = 1'b1;
          start      = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        mem_read   = 1'b1;
        proc_stall = 1'b1;
        if (mem_ready) state_d = FILL;
      end
      FILL: begin
        proc_stall = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q      <= IDLE;
      tgt_q        <= '0;
      victim_q     <= 1'b0;
      buf_q        <= '0;
      flush_pend_q <= 1'b0;
      lru_q        <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        tgt_q    <= tgt_line;
        victim_q <= victim;
      end
      if (state_q == REQ && mem_ready) buf_q <= mem_rdata;

      if (clr)                                flush_pend_q <= 1'b0;
      else if (proc_flush && state_q != IDLE) flush_pend_q <= 1'b1;

      // lru_q[s] names the least recently used way of set s.
      if (clr) begin
        lru_q <= '0;
      end else if (state_q == FILL) begin
        lru_q[tgt_set_q] <= ~victim_q;
      end else if (proc_read && !proc_stall) begin
        lru_q[set_a] <= ~hit_way_a;
        lru_q[set_b] <= ~hit_way_b;
      end
    end
  end

  assign mem_addr  = tgt_q;
  assign mem_write = 1'b0;
  assign mem_wdata = '0;

  logic unused_inputs;
  assign unused_inputs = ^{proc_write, proc_wdata};

endmodule
